button_event_arbiter: RTL
=========================

Name: button_event_arbiter

Overview:
- Sits directly downstream of the per-button two-flop synchronizer in the presentation controller.
- Debounces NUM_BTN already-synchronized button levels.
- Turns each debounced press (0->1) into a pending event.
- Round-robin arbitrates pending events onto a single valid/ready event channel consumed by the command encoder.

Parameters:
- NUM_BTN, 4, number of button channels (>=2).
- DEBOUNCE_CYCLES, 1000, consecutive differing samples required to accept a level change (>=2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- btn_sync  in  NUM_BTN  synchronized raw button levels (from synchronizer).
- btn_state  out  NUM_BTN  debounced button levels.
- evt_valid  out  1  event offered.
- evt_ready  in  1  consumer accepts event.
- evt_id  out  ID_W  index of offered button; ID_W=$clog2(NUM_BTN).
- evt_overflow  out  1  sticky: a press was lost.
- clear_overflow  in  1  clears evt_overflow.

Behaviour:
- Reset (rst high at posedge), state after that edge:
  - btn_state=0, all counters=0, pending=0.
  - evt_valid=0, evt_id=0, evt_overflow=0.
  - FSM=IDLE, last_grant=NUM_BTN-1, so channel 0 has first priority.
- Reset mid-operation drops any offered or pending event. Buttons held through reset are seen as new presses after debounce.
- Debounce, per channel i:
  - If btn_sync[i]==btn_state[i], cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: btn_state[i]<=btn_sync[i] and cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
  - Any sample equal to btn_state restarts the count, so glitches shorter than DEBOUNCE_CYCLES samples are ignored.
- Debounce latency: with btn_sync[i] changed and held from edge 1 onward, btn_state[i] changes at edge DEBOUNCE_CYCLES.
- Pending:
  - pending[i] sets on the same edge btn_state[i] goes 0->1.
  - Release (1->0) creates no event.
  - pending[i] clears on the edge where the event for i is accepted.
  - New press while pending[i] already set and not being accepted that edge: pending stays 1, evt_overflow<=1.
  - New press on the same edge as acceptance of i: pending[i] stays 1, no overflow.
- evt_overflow:
  - Clears on clear_overflow.
  - If clear_overflow and a new overflow occur on the same edge, the set wins.
- FSM, states IDLE and OFFER:
  - IDLE: if any pending, grant the first set bit searching from (last_grant+1) mod NUM_BTN upward with wrap. Then evt_id<=grant, evt_valid<=1, go to OFFER. If nothing is pending, stay in IDLE.
  - OFFER: evt_valid=1 and evt_id held stable until evt_ready.
  - OFFER on evt_ready: clear pending[evt_id], last_grant<=evt_id, evt_valid<=0, go to IDLE.
  - evt_valid never drops without acceptance, except on reset.
- Timing and throughput:
  - Arbitration looks at pending as registered before the edge.
  - A pending bit set at edge E gives evt_valid=1 after edge E+1.
  - Maximum throughput is one event per 2 cycles.
- evt_id is only meaningful while evt_valid=1. It holds its last value otherwise.

Decomposition:
- Package ppt_pkg:
  - arbiter state enum {IDLE, OFFER}.
  - default NUM_BTN and DEBOUNCE_CYCLES constants.
  - ID_W helper.
- Sub-module debounce_channel:
  - one channel: counter plus stable level.
  - outputs: level, rise pulse.
  - instantiated NUM_BTN times via generate.
- The arbiter, pending register and FSM live in the top module.

Test Plan:
- Single press (DEBOUNCE_CYCLES=4, NUM_BTN=4, evt_ready=1): btn_sync[1] 0->1 held.
  - Required: btn_state[1]=1 at edge 4, evt_valid=1 with evt_id=1 after edge 5, accepted, exactly one event total.
  - Releasing btn_sync[1] gives btn_state[1]=0 four edges later and no event.
- Bounce: btn_sync[2] high for 3 cycles, low 1, high 3, low.
  - Required: btn_state[2] stays 0, no event.
- Round-robin: btn_sync[0] and btn_sync[2] rise on the same cycle, evt_ready=1.
  - Required: evt_id sequence 0 then 2.
  - Then press 0 and 3 together: sequence 3 then 0 (last_grant=2).
- Backpressure/overflow: evt_ready=0, press btn 3, release, press again after debounce.
  - Required: evt_valid held with evt_id=3 throughout, evt_overflow=1.
  - After evt_ready=1, exactly one event for 3.
  - clear_overflow gives evt_overflow=0.
- Accept-plus-press collision: arrange btn_state[0] rise on the same edge as acceptance of id 0.
  - Required: evt_overflow=0, second event id 0 follows.
- Reset mid-offer: rst during OFFER with btn_sync[1] held high.
  - Required: evt_valid=0, btn_state=0 after the reset edge.
  - Then a fresh event id=1 after DEBOUNCE_CYCLES+1 edges.

Source files
------------

// File: rtl/ppt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppt_pkg
// Description : Shared types and defaults for the presentation-controller
//               button path (debounce + event arbitration).
// Revision    : 1.0 - initial release
// ============================================================================
package ppt_pkg;

   localparam int DEFAULT_NUM_BTN         = 4;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

   // Arbiter FSM: waiting for a pending press, or holding an offered event
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

   // Width of a button index; never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : Single-button debouncer. The stable level follows the input
//               only after DEBOUNCE_CYCLES consecutive differing samples.
//               rise flags the edge on which level goes 0->1.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 1000,
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic sync,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             at_max;

   assign at_max = (cnt == CNT_MAX);

   // Rise is flagged on the same edge that level will flip from 0 to 1
   assign rise = sync & ~level & at_max & ~rst;

   // Count consecutive samples that differ from the stable level
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (sync == level) begin
         cnt   <= '0;
      end else if (at_max) begin
         level <= sync;
         cnt   <= '0;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : Debounces NUM_BTN synchronized button levels, turns each
//               debounced press into a pending event and round-robin
//               arbitrates the pending events onto one valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter
   import ppt_pkg::*;
#(
   parameter int NUM_BTN         = DEFAULT_NUM_BTN,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   localparam int ID_W = id_width(NUM_BTN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_sync,
   output logic [NUM_BTN-1:0] btn_state,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [ID_W-1:0]    evt_id,
   output logic               evt_overflow,
   input  logic               clear_overflow
);

   arb_state_t         state;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] pending;
   logic [NUM_BTN-1:0] accept_vec;
   logic [ID_W-1:0]    last_grant;
   logic [ID_W-1:0]    grant;
   logic               grant_found;
   logic               accept;
   logic               ovf_set;

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_debounce
         debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .sync  (btn_sync[i]),
            .level (btn_state[i]),
            .rise  (rise[i])
         );
      end
   endgenerate

   assign accept     = (state == OFFER) && evt_ready;
   assign accept_vec = accept ? (NUM_BTN'(1) << evt_id) : '0;

   // A press landing on an already pending, not-being-accepted channel is lost
   assign ovf_set = |(rise & pending & ~accept_vec);

   // Round-robin pick: first pending bit after last_grant, wrapping around
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      for (int k = 1; k <= NUM_BTN; k++) begin
         int idx;
         idx = (int'(last_grant) + k) % NUM_BTN;
         if (!grant_found && pending[idx[ID_W-1:0]]) begin
            grant       = ID_W'(idx);
            grant_found = 1'b1;
         end
      end
   end

   // Pending presses and sticky overflow; a fresh press beats acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         pending      <= '0;
         evt_overflow <= 1'b0;
      end else begin
         pending <= (pending & ~accept_vec) | rise;
         if (ovf_set) begin
            evt_overflow <= 1'b1;
         end else if (clear_overflow) begin
            evt_overflow <= 1'b0;
         end
      end
   end

   // Offer FSM: grant from IDLE, hold the offer stable until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         evt_valid  <= 1'b0;
         evt_id     <= '0;
         last_grant <= ID_W'(NUM_BTN - 1);
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  evt_id    <= grant;
                  evt_valid <= 1'b1;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               if (evt_ready) begin
                  last_grant <= evt_id;
                  evt_valid  <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               evt_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
